alu_arbiter: RTL and testbench

- Shares one combinational ALU between two requesters: requester 0 is the execute stage and requester 1 is the address/branch helper.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Only one operation is in flight at a time. Operands are registered into the ALU, and the result is registered back before it is presented.
- Arbitration is round-robin by default.

---
 rtl/alu_arbiter.sv | 149 ++++++++++++++
 tb/tb_alu_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU: one operation in flight, operands and result registered.
// Build option: define ALU_ARB_FIXED_PRIO_EN to let requester 0 always win ties instead of round-robin.
module alu_arbiter #(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 3
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              r0_valid,
   output logic              r0_ready,
   input  logic [WIDTH-1:0]  r0_srcA,
   input  logic [WIDTH-1:0]  r0_srcB,
   input  logic [CTRL_W-1:0] r0_ctrl,
   output logic              r0_rsp_valid,
   input  logic              r0_rsp_ready,

   input  logic              r1_valid,
   output logic              r1_ready,
   input  logic [WIDTH-1:0]  r1_srcA,
   input  logic [WIDTH-1:0]  r1_srcB,
   input  logic [CTRL_W-1:0] r1_ctrl,
   output logic              r1_rsp_valid,
   input  logic              r1_rsp_ready,

   output logic [WIDTH-1:0]  rsp_result,
   output logic              rsp_zero,

   output logic [WIDTH-1:0]  alu_srcA,
   output logic [WIDTH-1:0]  alu_srcB,
   output logic [CTRL_W-1:0] alu_ctrl,
   input  logic [WIDTH-1:0]  alu_result,
   input  logic              alu_zero,

   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;

   logic   owner_q;
   logic   sel;
   logic   any_valid;
   logic   accept;
   logic   owner_rsp_ready;

   // Requester selection: sel = 1 picks requester 1.
`ifdef ALU_ARB_FIXED_PRIO_EN
   always_comb begin
      sel = ~r0_valid;
   end
`else
   logic last_grant_q;

   always_comb begin
      if (r0_valid && r1_valid) begin
         sel = ~last_grant_q;
      end else begin
         sel = ~r0_valid;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q <= 1'b1;
      end else if (accept) begin
         last_grant_q <= sel;
      end
   end
`endif

   // Ready is masked while reset is held so every output reads 0 in reset.
   assign any_valid       = r0_valid | r1_valid;
   assign accept          = (state_q == IDLE) && any_valid && !rst;
   assign r0_ready        = accept && !sel;
   assign r1_ready        = accept && sel;
   assign owner_rsp_ready = owner_q ? r1_rsp_ready : r0_rsp_ready;
   assign busy            = (state_q != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            state_d = RESP;
         end
         RESP: begin
            if (owner_rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Stage p0: operand capture on accept; alu_* hold their value until the next accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_srcA <= '0;
         alu_srcB <= '0;
         alu_ctrl <= '0;
         owner_q  <= 1'b0;
      end else if (accept) begin
         alu_srcA <= sel ? r1_srcA : r0_srcA;
         alu_srcB <= sel ? r1_srcB : r0_srcB;
         alu_ctrl <= sel ? r1_ctrl : r0_ctrl;
         owner_q  <= sel;
      end
   end

   // Stage p1: result capture at the end of EXEC, held until the owner consumes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_result   <= '0;
         rsp_zero     <= 1'b0;
         r0_rsp_valid <= 1'b0;
         r1_rsp_valid <= 1'b0;
      end else if (state_q == EXEC) begin
         rsp_result   <= alu_result;
         rsp_zero     <= alu_zero;
         r0_rsp_valid <= ~owner_q;
         r1_rsp_valid <= owner_q;
      end else if ((state_q == RESP) && owner_rsp_ready) begin
         r0_rsp_valid <= 1'b0;
         r1_rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single transactions plus hand sequences for backpressure, back-to-back ties and reset.
module tb_alu_arbiter;

   localparam int WIDTH  = 32;
   localparam int CTRL_W = 3;
`ifdef ALU_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready;
   logic              r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready;
   logic [WIDTH-1:0]  r0_srcA, r0_srcB, r1_srcA, r1_srcB;
   logic [CTRL_W-1:0] r0_ctrl, r1_ctrl;
   logic [WIDTH-1:0]  rsp_result;
   logic              rsp_zero;
   logic [WIDTH-1:0]  alu_srcA, alu_srcB, alu_result;
   logic [CTRL_W-1:0] alu_ctrl;
   logic              alu_zero;
   logic              busy;

   alu_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
      .clk(clk), .rst(rst),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_srcA(r0_srcA), .r0_srcB(r0_srcB),
      .r0_ctrl(r0_ctrl), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_srcA(r1_srcA), .r1_srcB(r1_srcB),
      .r1_ctrl(r1_ctrl), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero),
      .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Stand-in for the shared combinational ALU.
   always_comb begin
      case (alu_ctrl)
         3'b000:  alu_result = alu_srcA + alu_srcB;
         3'b001:  alu_result = alu_srcA - alu_srcB;
         3'b010:  alu_result = alu_srcA & alu_srcB;
         3'b011:  alu_result = alu_srcA | alu_srcB;
         3'b100:  alu_result = alu_srcA ^ alu_srcB;
         3'b101:  alu_result = alu_srcA << alu_srcB[4:0];
         3'b110:  alu_result = alu_srcA >> alu_srcB[4:0];
         default: alu_result = '0;
      endcase
      alu_zero = (alu_result == '0);
   end

   int tests = 0;
   int fails = 0;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic wait_grant(input string name, output bit ok, output bit who);
      ok  = 1'b0;
      who = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (r0_ready || r1_ready) begin
            ok  = 1'b1;
            who = r1_ready;
            break;
         end
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: no ready within 10 cycles, expected a grant", name);
      end else begin
         chk1({name, " one-ready"}, r0_ready & r1_ready, 1'b0);
      end
   endtask

   task automatic check_all_zero(input string name);
      chk1({name, " r0_ready"}, r0_ready, 1'b0);
      chk1({name, " r1_ready"}, r1_ready, 1'b0);
      chk1({name, " r0_rsp_valid"}, r0_rsp_valid, 1'b0);
      chk1({name, " r1_rsp_valid"}, r1_rsp_valid, 1'b0);
      chk32({name, " rsp_result"}, rsp_result, 32'h0);
      chk1({name, " rsp_zero"}, rsp_zero, 1'b0);
      chk32({name, " alu_srcA"}, alu_srcA, 32'h0);
      chk32({name, " alu_srcB"}, alu_srcB, 32'h0);
      chk32({name, " alu_ctrl"}, 32'(alu_ctrl), 32'h0);
      chk1({name, " busy"}, busy, 1'b0);
   endtask

   typedef struct {
      bit          v0, v1;
      logic [31:0] a0, b0;
      logic [2:0]  c0;
      logic [31:0] a1, b1;
      logic [2:0]  c1;
      bit          g;
      logic [31:0] res0;
      bit          z0;
      logic [31:0] res1;
      bit          z1;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs[NV];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          ok, who;
      int          acc_cyc[3];
      bit          acc_who[3];
      int          nacc;
      logic [31:0] exp_res;
      bit          exp_z;
      string       tag;

      // Tie grants alternate from reset under round-robin; fixed priority always picks r0.
      vecs[0] = '{1, 1, 32'd7, 32'd7, 3'b001, 32'hF0, 32'h0F, 3'b011, 1'b0, 32'h0, 1, 32'hFF, 0};
      vecs[1] = '{1, 1, 32'd7, 32'd7, 3'b001, 32'hF0, 32'h0F, 3'b011, FIXED ? 1'b0 : 1'b1, 32'h0, 1, 32'hFF, 0};
      vecs[2] = '{1, 1, 32'd7, 32'd7, 3'b001, 32'hF0, 32'h0F, 3'b011, 1'b0, 32'h0, 1, 32'hFF, 0};
      vecs[3] = '{0, 1, 32'd0, 32'd0, 3'b000, 32'hFFFF0000, 32'h0000FFFF, 3'b100, 1'b1, 32'h0, 1, 32'hFFFFFFFF, 0};
      vecs[4] = '{1, 0, 32'd5, 32'd3, 3'b000, 32'd0, 32'd0, 3'b000, 1'b0, 32'd8, 0, 32'h0, 1};
      vecs[5] = '{1, 0, 32'd1, 32'd4, 3'b101, 32'd0, 32'd0, 3'b000, 1'b0, 32'd16, 0, 32'h0, 1};
      vecs[6] = '{1, 0, 32'h1234, 32'h5678, 3'b111, 32'd0, 32'd0, 3'b000, 1'b0, 32'h0, 1, 32'h0, 1};
      vecs[7] = '{0, 1, 32'd0, 32'd0, 3'b000, 32'hF0F0, 32'hFF00, 3'b010, 1'b1, 32'h0, 1, 32'hF000, 0};
      vecs[8] = '{1, 1, 32'hFFFFFFFF, 32'd1, 3'b000, 32'd10, 32'd3, 3'b001, 1'b0, 32'h0, 1, 32'd7, 0};
      vecs[9] = '{1, 1, 32'hFFFFFFFF, 32'd1, 3'b000, 32'd10, 32'd3, 3'b001, FIXED ? 1'b0 : 1'b1, 32'h0, 1, 32'd7, 0};

      rst = 1'b1;
      r0_valid = 1'b1; r1_valid = 1'b1;
      r0_srcA = 32'd9; r0_srcB = 32'd9; r0_ctrl = 3'b000;
      r1_srcA = 32'd9; r1_srcB = 32'd9; r1_ctrl = 3'b000;
      r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;

      // Vector table: one full transaction per entry, rsp_ready held high.
      for (int i = 0; i < NV; i++) begin
         @(posedge clk); #1;
         r0_valid = vecs[i].v0; r0_srcA = vecs[i].a0; r0_srcB = vecs[i].b0; r0_ctrl = vecs[i].c0;
         r1_valid = vecs[i].v1; r1_srcA = vecs[i].a1; r1_srcB = vecs[i].b1; r1_ctrl = vecs[i].c1;
         r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
         tag = $sformatf("v%0d", i);
         wait_grant({tag, " grant"}, ok, who);
         if (ok) begin
            chk1({tag, " granted requester"}, who, vecs[i].g);
            @(posedge clk); #1;
            r0_valid = 1'b0; r1_valid = 1'b0;
            @(negedge clk);
            chk32({tag, " exec alu_srcA"}, alu_srcA, vecs[i].g ? vecs[i].a1 : vecs[i].a0);
            chk32({tag, " exec alu_ctrl"}, 32'(alu_ctrl), 32'(vecs[i].g ? vecs[i].c1 : vecs[i].c0));
            chk1({tag, " exec busy"}, busy, 1'b1);
            chk1({tag, " exec no rsp"}, r0_rsp_valid | r1_rsp_valid, 1'b0);
            @(negedge clk);
            exp_res = vecs[i].g ? vecs[i].res1 : vecs[i].res0;
            exp_z   = vecs[i].g ? vecs[i].z1 : vecs[i].z0;
            chk1({tag, " r0_rsp_valid"}, r0_rsp_valid, !vecs[i].g);
            chk1({tag, " r1_rsp_valid"}, r1_rsp_valid, vecs[i].g);
            chk32({tag, " rsp_result"}, rsp_result, exp_res);
            chk1({tag, " rsp_zero"}, rsp_zero, exp_z);
            chk1({tag, " resp busy"}, busy, 1'b1);
            @(negedge clk);
            chk1({tag, " idle busy"}, busy, 1'b0);
            chk1({tag, " idle rsp_valid"}, r0_rsp_valid | r1_rsp_valid, 1'b0);
         end
      end

      // Response backpressure on r1 while r0 waits and r0_rsp_ready is high.
      @(posedge clk); #1;
      r1_valid = 1'b1; r1_srcA = 32'hFFFF0000; r1_srcB = 32'h0000FFFF; r1_ctrl = 3'b100;
      r1_rsp_ready = 1'b0; r0_rsp_ready = 1'b1;
      wait_grant("bp grant", ok, who);
      chk1("bp granted r1", who, 1'b1);
      @(posedge clk); #1;
      r1_valid = 1'b0;
      r0_valid = 1'b1; r0_srcA = 32'd2; r0_srcB = 32'd2; r0_ctrl = 3'b000;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         tag = $sformatf("bp hold%0d", k);
         chk1({tag, " r1_rsp_valid"}, r1_rsp_valid, 1'b1);
         chk1({tag, " r0_rsp_valid"}, r0_rsp_valid, 1'b0);
         chk32({tag, " rsp_result"}, rsp_result, 32'hFFFFFFFF);
         chk1({tag, " r0_ready"}, r0_ready, 1'b0);
         chk32({tag, " alu_srcA"}, alu_srcA, 32'hFFFF0000);
      end
      @(posedge clk); #1;
      r1_rsp_ready = 1'b1;
      @(negedge clk);
      chk1("bp release r1_rsp_valid", r1_rsp_valid, 1'b1);
      @(negedge clk);
      chk1("bp done r1_rsp_valid", r1_rsp_valid, 1'b0);
      chk1("bp done busy", busy, 1'b0);
      chk1("bp r0_ready next", r0_ready, 1'b1);
      @(posedge clk); #1;
      r0_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk1("bp r0 rsp_valid", r0_rsp_valid, 1'b1);
      chk32("bp r0 result", rsp_result, 32'd4);
      @(negedge clk);
      chk1("bp r0 done busy", busy, 1'b0);

      // Back-to-back ties from a fresh reset: three accepts, 3 cycles apart.
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      r0_valid = 1'b1; r0_srcA = 32'd7; r0_srcB = 32'd7; r0_ctrl = 3'b001;
      r1_valid = 1'b1; r1_srcA = 32'hF0; r1_srcB = 32'h0F; r1_ctrl = 3'b011;
      r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
      nacc = 0;
      for (int c = 0; c < 20 && nacc < 3; c++) begin
         @(negedge clk);
         if (r0_ready || r1_ready) begin
            acc_cyc[nacc] = c;
            acc_who[nacc] = r1_ready;
            nacc++;
         end
      end
      chk32("tie accept count", 32'(nacc), 32'd3);
      if (nacc == 3) begin
         chk1("tie grant0", acc_who[0], 1'b0);
         chk1("tie grant1", acc_who[1], FIXED ? 1'b0 : 1'b1);
         chk1("tie grant2", acc_who[2], 1'b0);
         chk32("tie interval1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
         chk32("tie interval2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
      end
      @(posedge clk); #1;
      r0_valid = 1'b0;
      wait_grant("tie r1 after drop", ok, who);
      chk1("tie r1 after drop who", who, 1'b1);
      @(posedge clk); #1;
      r1_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk1("tie r1 rsp_valid", r1_rsp_valid, 1'b1);
      chk32("tie r1 result", rsp_result, 32'hFF);
      @(negedge clk);

      // Reset during EXEC discards the operation and restores r0 tie priority.
      @(posedge clk); #1;
      r0_valid = 1'b1; r0_srcA = 32'd5; r0_srcB = 32'd3; r0_ctrl = 3'b000;
      wait_grant("rst grant", ok, who);
      chk1("rst granted r0", who, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1; r0_valid = 1'b1; r1_valid = 1'b1;
      @(negedge clk);
      check_all_zero("mid-op reset");
      @(posedge clk); #1;
      rst = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk1($sformatf("post-reset%0d rsp_valid", k), r0_rsp_valid | r1_rsp_valid, 1'b0);
         chk1($sformatf("post-reset%0d busy", k), busy, 1'b0);
      end
      @(posedge clk); #1;
      r0_valid = 1'b1; r1_valid = 1'b1;
      r0_srcA = 32'd5; r0_srcB = 32'd3; r0_ctrl = 3'b000;
      wait_grant("post-reset tie", ok, who);
      chk1("post-reset tie who", who, 1'b0);
      @(posedge clk); #1;
      r0_valid = 1'b0; r1_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk1("post-reset r0 rsp_valid", r0_rsp_valid, 1'b1);
      chk32("post-reset result", rsp_result, 32'd8);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
